// File: rtl/halfword_bank_ctrl.sv
// Load/store sequencer for two 16-bit single-port halfword banks: splits word
// accesses across banks, does read-modify-write for byte stores, one response per request.
module halfword_bank_ctrl #(
  parameter int ROW_W = 10,
  parameter int AW    = ROW_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic [AW-1:0]    req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [31:0]      rsp_rdata,
  output logic             b0_we,
  output logic             b1_we,
  output logic [ROW_W-1:0] b0_addr,
  output logic [ROW_W-1:0] b1_addr,
  output logic [15:0]      b0_din,
  output logic [15:0]      b1_din,
  input  logic [15:0]      b0_dout,
  input  logic [15:0]      b1_dout,
  output logic [2:0]       dbg_state
);

  // Handshake: a request is accepted on the rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE outside reset, and the response is a single
  // rsp_valid pulse with rsp_err/rsp_rdata qualified by it.

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, MERGE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t             r_state, w_state;
  logic               r_store, w_store;
  logic [1:0]         r_size, w_size;
  logic               r_byte_hi, w_byte_hi;
  logic               r_bank, w_bank;
  logic [7:0]         r_wbyte, w_wbyte;
  logic               r_b0_we, w_b0_we, r_b1_we, w_b1_we;
  logic [ROW_W-1:0]   r_b0_addr, w_b0_addr, r_b1_addr, w_b1_addr;
  logic [15:0]        r_b0_din, w_b0_din, r_b1_din, w_b1_din;
  logic               r_rsp_valid, w_rsp_valid;
  logic               r_rsp_err, w_rsp_err;
  logic [31:0]        r_rsp_rdata, w_rsp_rdata;

  logic               w_err;
  logic [ROW_W-1:0]   w_row, w_row_inc;
  logic [15:0]        w_sel, w_merged;
  logic [7:0]         w_sel_byte;

  assign w_err     = (req_size == 2'b11) || (req_addr[0] && (req_size != SZ_BYTE));
  assign w_row     = req_addr[AW-1:2];
  assign w_row_inc = w_row + {{(ROW_W-1){1'b0}}, 1'b1};

  // Byte paths only ever use the single bank chosen by H[0].
  assign w_sel      = r_bank ? b1_dout : b0_dout;
  assign w_sel_byte = r_byte_hi ? w_sel[15:8] : w_sel[7:0];
  assign w_merged   = r_byte_hi ? {r_wbyte, w_sel[7:0]} : {w_sel[15:8], r_wbyte};

  always_comb begin
    w_state     = r_state;
    w_store     = r_store;
    w_size      = r_size;
    w_byte_hi   = r_byte_hi;
    w_bank      = r_bank;
    w_wbyte     = r_wbyte;
    w_b0_we     = 1'b0;
    w_b1_we     = 1'b0;
    w_b0_addr   = r_b0_addr;
    w_b1_addr   = r_b1_addr;
    w_b0_din    = r_b0_din;
    w_b1_din    = r_b1_din;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = 32'h0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_store   = req_we;
          w_size    = req_size;
          w_byte_hi = req_addr[0];
          w_bank    = req_addr[1];
          w_wbyte   = req_wdata[7:0];
          if (w_err) begin
            w_state     = RESP;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
          end else begin
            w_state   = ISSUE;
            w_b0_addr = w_row;
            w_b1_addr = w_row;
            w_b0_din  = req_wdata[15:0];
            w_b1_din  = req_wdata[15:0];
            if (req_size == SZ_WORD) begin
              w_b0_we = req_we;
              w_b1_we = req_we;
              // Odd H: low half lives in bank1[row], high half in bank0[row+1].
              if (req_addr[1]) begin
                w_b0_addr = w_row_inc;
                w_b0_din  = req_wdata[31:16];
              end else begin
                w_b1_din  = req_wdata[31:16];
              end
            end else if (req_size == SZ_HALF) begin
              w_b0_we = req_we & ~req_addr[1];
              w_b1_we = req_we & req_addr[1];
            end
          end
        end
      end
      ISSUE: begin
        if (r_store && (r_size != SZ_BYTE)) begin
          w_state     = RESP;
          w_rsp_valid = 1'b1;
        end else begin
          w_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (r_store) begin
          w_state  = MERGE;
          w_b0_din = w_merged;
          w_b1_din = w_merged;
          w_b0_we  = ~r_bank;
          w_b1_we  = r_bank;
        end else begin
          w_state     = RESP;
          w_rsp_valid = 1'b1;
          case (r_size)
            SZ_WORD: w_rsp_rdata = r_bank ? {b0_dout, b1_dout} : {b1_dout, b0_dout};
            SZ_HALF: w_rsp_rdata = {16'h0, w_sel};
            default: w_rsp_rdata = {24'h0, w_sel_byte};
          endcase
        end
      end
      MERGE: begin
        w_state     = RESP;
        w_rsp_valid = 1'b1;
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_store     <= 1'b0;
      r_size      <= 2'b00;
      r_byte_hi   <= 1'b0;
      r_bank      <= 1'b0;
      r_wbyte     <= 8'h0;
      r_b0_we     <= 1'b0;
      r_b1_we     <= 1'b0;
      r_b0_addr   <= '0;
      r_b1_addr   <= '0;
      r_b0_din    <= 16'h0;
      r_b1_din    <= 16'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_state     <= w_state;
      r_store     <= w_store;
      r_size      <= w_size;
      r_byte_hi   <= w_byte_hi;
      r_bank      <= w_bank;
      r_wbyte     <= w_wbyte;
      r_b0_we     <= w_b0_we;
      r_b1_we     <= w_b1_we;
      r_b0_addr   <= w_b0_addr;
      r_b1_addr   <= w_b1_addr;
      r_b0_din    <= w_b0_din;
      r_b1_din    <= w_b1_din;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  assign req_ready = (r_state == IDLE) && !rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign b0_we     = r_b0_we;
  assign b1_we     = r_b1_we;
  assign b0_addr   = r_b0_addr;
  assign b1_addr   = r_b1_addr;
  assign b0_din    = r_b0_din;
  assign b1_din    = r_b1_din;
  assign dbg_state = r_state;

endmodule

// File: doc/halfword_bank_ctrl.md
Name: halfword_bank_ctrl

Overview:
- Sequencer between the CPU load/store path and the memory's two 16-bit halfword banks (bank0, bank1).
- Each bank is single-port with synchronous read: data appears one cycle after the address.
- The controller maps byte addresses onto the banks, splits word accesses across both banks, and does read-modify-write (RMW) for byte stores, because a bank write enable covers all 16 bits.
- Requests use a valid/ready handshake; each request gets exactly one response pulse.

Parameters:
- ROW_W, 10, bank row address width; each bank holds 2^ROW_W halfwords.
- AW, ROW_W+2, byte address width.

Ports:
- clk  in  1  memory clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  error flag, valid with rsp_valid.
- rsp_rdata  out  32  load data, zero-extended; 0 for stores and errors.
- b0_we, b1_we  out  1  bank write enables.
- b0_addr, b1_addr  out  ROW_W  bank row addresses.
- b0_din, b1_din  out  16  bank write data.
- b0_dout, b1_dout  in  16  bank read data, valid 1 cycle after address.

Behaviour:
- Reset values: req_ready=0 while rst is high; rsp_valid=0, rsp_err=0, rsp_rdata=0, b*_we=0, b*_addr=0, b*_din=0; state=IDLE.
- Reset mid-operation: the transaction is dropped, no response is issued, and no bank write occurs after the reset edge.
- All bank-side and response outputs are registered.
- req_ready=1 only in IDLE. Accept happens at the edge where req_valid && req_ready.
- Address mapping: H = addr>>1; bank = H[0]; row = H>>1.
- Word access, H even: low half = bank0[row], high half = bank1[row].
- Word access, H odd: low half = bank1[row], high half = bank0[row+1], with row+1 wrapping modulo 2^ROW_W.
- Halfword access uses a single bank.
- Byte access selects bits [7:0] if addr[0]=0, else [15:8].
- Errors:
  - req_size=11, or addr[0]=1 with a halfword or word access.
  - Controller goes IDLE→RESP, touches no bank, and responds with rsp_err=1.
  - Error response lands in cycle A+1, where A is the accept edge.
- States: IDLE, ISSUE, CAPTURE, MERGE, RESP.
- IDLE→ISSUE on a legal accept. The same edge registers addresses, din, and we. we is set only for word/halfword stores, and only on the banks involved.
- ISSUE (cycle A+1): banks sample. Then:
  - Store word/half → RESP.
  - Load → CAPTURE.
  - Byte store → CAPTURE, with we=0 (read phase).
- CAPTURE (cycle A+2): b*_dout valid.
  - Load: rsp_rdata is assembled and goes to RESP.
  - Byte store: the new byte is merged into the read halfword, din and we=1 are registered, and the state goes to MERGE.
- MERGE (cycle A+3): the bank writes the merged halfword → RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE; req_ready returns the following cycle.
- we is deasserted on every transition out of ISSUE/MERGE.
- Response timing after accept edge A (rsp_valid cycle):
  - error: A+1
  - word/half store: A+2
  - load: A+3
  - byte store: A+4
- No pipelining: one transaction outstanding.
- Read-after-write returns the new data, since the write completes before RESP.

Test Plan:
- Reset, then word store addr=0x000, data=0xDEADBEEF → bank0[0]=0xBEEF, bank1[0]=0xDEAD; rsp_valid at A+2 with rsp_err=0.
- Word store 0x11223344 at addr=0x006 (H=3, odd) → bank1[1]=0x3344, bank0[2]=0x1122. Word load at 0x006 → rsp_rdata=0x11223344 at A+3.
- Byte store 0xAA at addr=0x001 after the first test → bank0[0]=0xAAEF via RMW; no other bank row is written; rsp at A+4. Halfword load at 0x000 → 0x0000AAEF.
- Word access at top address (H = 2^(ROW_W+1)-1) → row+1 wraps to bank0 row 0; check the data round-trips.
- Halfword load at addr=0x003, and any req_size=11 → rsp_err=1 at A+1, rsp_rdata=0, no b*_we pulse.
- Assert rst in CAPTURE of a byte store → no bank write, no rsp_valid; req_ready=1 the cycle after rst drops; the next request completes normally.
